// File: rtl/uart_chan_mux_pkg.sv
// Package for uart_chan_mux.
// Holds the arbiter state type and helper functions that derive the
// payload width, the channel count and the channel id of a UART byte
// from the channel-id width CH_BITS (1..3).
package uart_chan_mux_pkg;

    // Widest supported channel id; chan_of returns this many bits.
    localparam int MAX_CH_BITS = 3;

    // TX arbiter states.
    typedef enum logic {
        IDLE = 1'b0,
        SENT = 1'b1
    } fsm_t;

    // Payload bits left in a byte once the channel id is taken from the top.
    function automatic int pw_of(input int ch_bits);
        return 8 - ch_bits;
    endfunction

    // Number of logical channels.
    function automatic int num_ch_of(input int ch_bits);
        return 1 << ch_bits;
    endfunction

    // Channel id carried in the top ch_bits bits of a byte.
    function automatic logic [MAX_CH_BITS-1:0] chan_of(input logic [7:0] b, input int ch_bits);
        return MAX_CH_BITS'(b >> (8 - ch_bits));
    endfunction

endpackage

// File: rtl/uart_chan_mux_if.sv
// UART-side bus of uart_chan_mux.
// The mux (slave) receives bytes from uart_rx and hands bytes to uart_tx.
// The UART side (master) drives the RX byte/strobe and the TX ready level.
//   i_rx_dat   : byte from uart_rx
//   i_rx_pulse : one-cycle strobe, i_rx_dat valid
//   o_tx_dat   : byte to uart_tx, {channel, payload}
//   o_tx_start : one-cycle start strobe to uart_tx
//   i_tx_ready : uart_tx idle
//
// Handshake: a byte is accepted from uart_rx in every cycle i_rx_pulse is
// high (no back-pressure). A TX byte is issued only while i_tx_ready is high;
// o_tx_start is high for exactly one cycle with o_tx_dat stable, and uart_tx
// drops i_tx_ready the cycle after it samples the start.
interface uart_chan_mux_if;
    logic [7:0] i_rx_dat;
    logic       i_rx_pulse;
    logic [7:0] o_tx_dat;
    logic       o_tx_start;
    logic       i_tx_ready;

    modport master (
        output i_rx_dat, i_rx_pulse, i_tx_ready,
        input  o_tx_dat, o_tx_start
    );

    modport slave (
        input  i_rx_dat, i_rx_pulse, i_tx_ready,
        output o_tx_dat, o_tx_start
    );
endinterface

// File: rtl/uart_chan_mux_chan_fifo.sv
// chan_fifo: show-ahead FIFO of 2**DEPTH_LOG2 entries of W bits.
//   i_clk, i_reset : clock, asynchronous active-high reset (empties FIFO)
//   i_dat, i_push  : write data / write request (ignored when full)
//   i_pop          : drop the head entry (ignored when empty)
//   o_dat          : head entry, valid while !o_empty
//   o_empty/o_full : occupancy flags, registered
// Full is judged on the count before this cycle's pop, so a push into a
// full FIFO is dropped even if a pop happens in the same cycle.
module chan_fifo #(
    parameter int W          = 7,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_dat,
    input  logic         i_push,
    input  logic         i_pop,
    output logic [W-1:0] o_dat,
    output logic         o_empty,
    output logic         o_full
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [W-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign o_empty = (count == '0);
    assign o_full  = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_dat   = mem[rd_ptr];

    // Pointers wrap naturally at DEPTH because they are DEPTH_LOG2 bits wide.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= i_dat;
    end
endmodule

// File: rtl/uart_chan_mux.sv
// uart_chan_mux: multiplexes one UART byte stream into NUM_CH = 2**CH_BITS
// logical channels. The top CH_BITS bits of each byte are the channel id,
// the low PW = 8-CH_BITS bits the payload.
//   i_clk, i_reset  : clock, asynchronous active-high reset
//   uart            : UART-side bus (RX byte in, TX byte out)
//   o_ch_rx_dat     : RX FIFO heads, channel c at [c*PW +: PW]
//   o_ch_rx_valid   : RX FIFO c non-empty
//   i_ch_rx_pop     : pop RX FIFO c
//   i_ch_tx_dat     : TX payloads, channel c at [c*PW +: PW]
//   i_ch_tx_push    : push TX FIFO c
//   o_ch_tx_full    : TX FIFO c full
//   o_rx_overflow   : sticky, an RX byte for channel c was dropped
//   i_clr_overflow  : clear overflow bit c (a same-cycle new overflow wins)
//   i_int_en        : per-channel interrupt mask
//   o_int           : masked RX-valid or overflow interrupt
//   o_dbg_state     : TX arbiter state
module uart_chan_mux
    import uart_chan_mux_pkg::*;
#(
    parameter  int CH_BITS    = 1,
    parameter  int DEPTH_LOG2 = 2,
    localparam int PW         = pw_of(CH_BITS),
    localparam int NUM_CH     = num_ch_of(CH_BITS)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    uart_chan_mux_if.slave       uart,
    output logic [NUM_CH*PW-1:0] o_ch_rx_dat,
    output logic [NUM_CH-1:0]    o_ch_rx_valid,
    input  logic [NUM_CH-1:0]    i_ch_rx_pop,
    input  logic [NUM_CH*PW-1:0] i_ch_tx_dat,
    input  logic [NUM_CH-1:0]    i_ch_tx_push,
    output logic [NUM_CH-1:0]    o_ch_tx_full,
    output logic [NUM_CH-1:0]    o_rx_overflow,
    input  logic [NUM_CH-1:0]    i_clr_overflow,
    input  logic [NUM_CH-1:0]    i_int_en,
    output logic                 o_int,
    output fsm_t                 o_dbg_state
);
    logic [MAX_CH_BITS-1:0] rx_ch;
    logic [NUM_CH-1:0]      rx_sel;
    logic [NUM_CH-1:0]      rx_push;
    logic [NUM_CH-1:0]      rx_full;
    logic [NUM_CH-1:0]      ovf_set;
    logic [NUM_CH-1:0]      ovf_q;

    logic [NUM_CH*PW-1:0]   tx_head;
    logic [NUM_CH-1:0]      tx_empty;
    logic [NUM_CH-1:0]      tx_pop;

    fsm_t                   state_q;
    fsm_t                   state_d;
    logic [CH_BITS-1:0]     last_q;
    logic [CH_BITS-1:0]     grant;
    logic [CH_BITS-1:0]     idx;
    logic                   grant_found;
    logic                   grant_go;
    logic [7:0]             tx_dat_q;
    logic                   tx_start_q;

    assign rx_ch = chan_of(uart.i_rx_dat, CH_BITS);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic rx_empty;

        assign rx_sel[c]  = uart.i_rx_pulse && (rx_ch == MAX_CH_BITS'(c));
        assign rx_push[c] = rx_sel[c] && !rx_full[c];
        // Full is sampled before any same-cycle pop, so the byte is dropped.
        assign ovf_set[c] = rx_sel[c] && rx_full[c];

        chan_fifo #(.W(PW), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_dat   (uart.i_rx_dat[PW-1:0]),
            .i_push  (rx_push[c]),
            .i_pop   (i_ch_rx_pop[c]),
            .o_dat   (o_ch_rx_dat[c*PW +: PW]),
            .o_empty (rx_empty),
            .o_full  (rx_full[c])
        );
        assign o_ch_rx_valid[c] = !rx_empty;

        chan_fifo #(.W(PW), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_dat   (i_ch_tx_dat[c*PW +: PW]),
            .i_push  (i_ch_tx_push[c]),
            .i_pop   (tx_pop[c]),
            .o_dat   (tx_head[c*PW +: PW]),
            .o_empty (tx_empty[c]),
            .o_full  (o_ch_tx_full[c])
        );
    end

    // Round-robin search: walk the channels starting one past the last grant.
    // The CH_BITS-wide idx wraps modulo NUM_CH, so the last step revisits last_q.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        idx         = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = last_q + CH_BITS'(i);
            if (!grant_found && !tx_empty[idx]) begin
                grant_found = 1'b1;
                grant       = idx;
            end
        end
    end

    // Arbiter next-state. SENT is a single cycle that covers the start strobe,
    // giving uart_tx time to drop i_tx_ready before IDLE looks at it again.
    always_comb begin
        state_d  = state_q;
        grant_go = 1'b0;
        tx_pop   = '0;
        case (state_q)
            IDLE: begin
                if (uart.i_tx_ready && grant_found) begin
                    grant_go      = 1'b1;
                    tx_pop[grant] = 1'b1;
                    state_d       = SENT;
                end
            end
            SENT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            last_q     <= '1;  // channel 0 is searched first after reset
            tx_dat_q   <= '0;
            tx_start_q <= 1'b0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= grant_go;
            if (grant_go) begin
                last_q   <= grant;
                tx_dat_q <= {grant, tx_head[grant*PW +: PW]};
            end
            // A new overflow wins over a same-cycle clear.
            ovf_q <= (ovf_q & ~i_clr_overflow) | ovf_set;
        end
    end

    assign uart.o_tx_dat   = tx_dat_q;
    assign uart.o_tx_start = tx_start_q;
    assign o_rx_overflow   = ovf_q;
    assign o_int           = |(o_ch_rx_valid & i_int_en) | |(ovf_q & i_int_en);
    assign o_dbg_state     = state_q;
endmodule

// File: tb/tb_uart_chan_mux.sv
// Self-checking bench for uart_chan_mux.
// dut_a (CH_BITS=1) covers RX tagging, overflow and FIFO boundaries with a
// vector table; dut_b (CH_BITS=2) covers the TX arbiter, TX full and an
// asynchronous reset with hand-written sequences.
module tb_uart_chan_mux;
    import uart_chan_mux_pkg::*;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // dut_a: CH_BITS=1, PW=7, 2 channels
    uart_chan_mux_if if_a ();
    logic [13:0] a_rx_dat;
    logic [1:0]  a_rx_valid, a_rx_pop, a_tx_push, a_tx_full, a_ovf, a_clr, a_int_en;
    logic [13:0] a_tx_dat;
    logic        a_int;
    fsm_t        a_state;

    uart_chan_mux #(.CH_BITS(1), .DEPTH_LOG2(2)) dut_a (
        .i_clk          (clk),
        .i_reset        (rst_a),
        .uart           (if_a.slave),
        .o_ch_rx_dat    (a_rx_dat),
        .o_ch_rx_valid  (a_rx_valid),
        .i_ch_rx_pop    (a_rx_pop),
        .i_ch_tx_dat    (a_tx_dat),
        .i_ch_tx_push   (a_tx_push),
        .o_ch_tx_full   (a_tx_full),
        .o_rx_overflow  (a_ovf),
        .i_clr_overflow (a_clr),
        .i_int_en       (a_int_en),
        .o_int          (a_int),
        .o_dbg_state    (a_state)
    );

    // dut_b: CH_BITS=2, PW=6, 4 channels
    uart_chan_mux_if if_b ();
    logic [23:0] b_rx_dat;
    logic [3:0]  b_rx_valid, b_rx_pop, b_tx_push, b_tx_full, b_ovf, b_clr, b_int_en;
    logic [23:0] b_tx_dat;
    logic        b_int;
    fsm_t        b_state;

    uart_chan_mux #(.CH_BITS(2), .DEPTH_LOG2(2)) dut_b (
        .i_clk          (clk),
        .i_reset        (rst_b),
        .uart           (if_b.slave),
        .o_ch_rx_dat    (b_rx_dat),
        .o_ch_rx_valid  (b_rx_valid),
        .i_ch_rx_pop    (b_rx_pop),
        .i_ch_tx_dat    (b_tx_dat),
        .i_ch_tx_push   (b_tx_push),
        .o_ch_tx_full   (b_tx_full),
        .o_rx_overflow  (b_ovf),
        .i_clr_overflow (b_clr),
        .i_int_en       (b_int_en),
        .o_int          (b_int),
        .o_dbg_state    (b_state)
    );

    // Scoreboard of bytes expected on dut_b's transmitter, in order.
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] dat;
        logic       pulse;
        logic [1:0] pop;
        logic [1:0] clr;
        logic [1:0] int_en;
        logic [1:0] exp_valid;
        logic [6:0] exp_h0;
        logic [6:0] exp_h1;
        logic [1:0] exp_ovf;
        logic       exp_int;
    } vec_t;

    vec_t vecs[17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // uart_tx model for dut_b: on a start it goes busy (ready low) for 10
    // cycles. Every start is checked against the scoreboard and must last
    // exactly one cycle. Runs the full budget so extra bytes are caught.
    task automatic run_tx(input int budget);
        logic prev_start = 1'b0;
        int   busy       = 0;
        logic [7:0] e;
        if_b.i_tx_ready = 1'b1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            tick();
            if (prev_start) check("tx_start_width", 32'(if_b.o_tx_start), 32'd0);
            if (if_b.o_tx_start && !prev_start) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL tx_extra: got %0h expected no byte", if_b.o_tx_dat);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", 32'(if_b.o_tx_dat), 32'(e));
                end
                if_b.i_tx_ready = 1'b0;
                busy = 10;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) if_b.i_tx_ready = 1'b1;
            end
            prev_start = if_b.o_tx_start;
        end
        check("tx_missing", 32'(exp_q.size()), 32'd0);
        if_b.i_tx_ready = 1'b0;
    endtask

    // Watchdog: a stuck run still reports.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // dat, pulse, pop, clr, int_en, exp_valid, exp_h0, exp_h1, exp_ovf, exp_int
        vecs[0]  = '{8'h41, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 7'h41, 7'h00, 2'b00, 1'b0};
        vecs[1]  = '{8'hC2, 1'b1, 2'b00, 2'b00, 2'b11, 2'b11, 7'h41, 7'h42, 2'b00, 1'b1};
        vecs[2]  = '{8'h00, 1'b0, 2'b11, 2'b00, 2'b11, 2'b00, 7'h00, 7'h00, 2'b00, 1'b0};
        vecs[3]  = '{8'h01, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 7'h01, 7'h00, 2'b00, 1'b0};
        vecs[4]  = '{8'h02, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 7'h01, 7'h00, 2'b00, 1'b0};
        vecs[5]  = '{8'h03, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 7'h01, 7'h00, 2'b00, 1'b0};
        vecs[6]  = '{8'h04, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 7'h01, 7'h00, 2'b00, 1'b0};
        vecs[7]  = '{8'h05, 1'b1, 2'b00, 2'b00, 2'b01, 2'b01, 7'h01, 7'h00, 2'b01, 1'b1};
        vecs[8]  = '{8'h00, 1'b0, 2'b00, 2'b01, 2'b01, 2'b01, 7'h01, 7'h00, 2'b00, 1'b1};
        // full + pop + clear in one cycle: pop happens, byte dropped, set wins
        vecs[9]  = '{8'h06, 1'b1, 2'b01, 2'b01, 2'b00, 2'b01, 7'h02, 7'h00, 2'b01, 1'b0};
        vecs[10] = '{8'h00, 1'b0, 2'b01, 2'b00, 2'b10, 2'b01, 7'h03, 7'h00, 2'b01, 1'b0};
        vecs[11] = '{8'h00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 7'h04, 7'h00, 2'b01, 1'b0};
        vecs[12] = '{8'h00, 1'b0, 2'b01, 2'b00, 2'b01, 2'b00, 7'h00, 7'h00, 2'b01, 1'b1};
        // pop on empty ch0 ignored
        vecs[13] = '{8'h85, 1'b1, 2'b01, 2'b00, 2'b10, 2'b10, 7'h00, 7'h05, 2'b01, 1'b1};
        vecs[14] = '{8'h00, 1'b0, 2'b00, 2'b01, 2'b01, 2'b10, 7'h00, 7'h05, 2'b00, 1'b0};
        // push and pop on a one-entry FIFO keeps it at one entry
        vecs[15] = '{8'h86, 1'b1, 2'b10, 2'b00, 2'b00, 2'b10, 7'h00, 7'h06, 2'b00, 1'b0};
        vecs[16] = '{8'h00, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 7'h00, 7'h00, 2'b00, 1'b0};

        // Clock/reset
        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.i_rx_dat = '0; if_a.i_rx_pulse = 1'b0; if_a.i_tx_ready = 1'b0;
        if_b.i_rx_dat = '0; if_b.i_rx_pulse = 1'b0; if_b.i_tx_ready = 1'b0;
        a_rx_pop = '0; a_tx_dat = '0; a_tx_push = '0; a_clr = '0; a_int_en = 2'b11;
        b_rx_pop = '0; b_tx_dat = '0; b_tx_push = '0; b_clr = '0; b_int_en = 4'hF;
        repeat (3) tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();

        // Reset state
        check("rst_a_valid", 32'(a_rx_valid), 32'd0);
        check("rst_a_ovf",   32'(a_ovf),      32'd0);
        check("rst_a_int",   32'(a_int),      32'd0);
        check("rst_a_full",  32'(a_tx_full),  32'd0);
        check("rst_b_start", 32'(if_b.o_tx_start), 32'd0);
        check("rst_b_dat",   32'(if_b.o_tx_dat),   32'd0);
        check("rst_b_full",  32'(b_tx_full),  32'd0);
        check("rst_b_valid", 32'(b_rx_valid), 32'd0);
        check("rst_b_int",   32'(b_int),      32'd0);
        check("rst_b_state", 32'(b_state),    32'(IDLE));
        b_int_en = '0;

        // RX table on dut_a
        for (int i = 0; i < 17; i++) begin
            if_a.i_rx_dat   = vecs[i].dat;
            if_a.i_rx_pulse = vecs[i].pulse;
            a_rx_pop        = vecs[i].pop;
            a_clr           = vecs[i].clr;
            a_int_en        = vecs[i].int_en;
            tick();
            check($sformatf("v%0d_valid", i), 32'(a_rx_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_ovf", i),   32'(a_ovf),      32'(vecs[i].exp_ovf));
            check($sformatf("v%0d_int", i),   32'(a_int),      32'(vecs[i].exp_int));
            if (vecs[i].exp_valid[0]) check($sformatf("v%0d_head0", i), 32'(a_rx_dat[6:0]),  32'(vecs[i].exp_h0));
            if (vecs[i].exp_valid[1]) check($sformatf("v%0d_head1", i), 32'(a_rx_dat[13:7]), 32'(vecs[i].exp_h1));
            if_a.i_rx_pulse = 1'b0;
            a_rx_pop        = '0;
            a_clr           = '0;
        end

        // Round-robin: two bytes in every TX FIFO, served 0,1,2,3,0,1,2,3
        b_tx_dat  = {6'h13, 6'h12, 6'h11, 6'h10};
        b_tx_push = 4'hF;
        tick();
        b_tx_dat  = {6'h23, 6'h22, 6'h21, 6'h20};
        tick();
        b_tx_push = '0;
        check("rr_not_full", 32'(b_tx_full), 32'd0);
        exp_q = '{8'h10, 8'h51, 8'h92, 8'hD3, 8'h20, 8'h61, 8'hA2, 8'hE3};
        run_tx(200);

        // Push-to-start latency: push in N, start in N+2
        if_b.i_tx_ready = 1'b1;
        b_tx_dat        = '0;
        b_tx_dat[12 +: 6] = 6'h15;
        b_tx_push       = 4'b0100;
        tick();
        b_tx_push = '0;
        check("lat_n1_start", 32'(if_b.o_tx_start), 32'd0);
        tick();
        check("lat_n2_start", 32'(if_b.o_tx_start), 32'd1);
        check("lat_n2_dat",   32'(if_b.o_tx_dat),   32'h95);
        check("lat_n2_state", 32'(b_state),         32'(SENT));
        if_b.i_tx_ready = 1'b0;
        tick();
        check("lat_n3_start", 32'(if_b.o_tx_start), 32'd0);
        check("lat_n3_state", 32'(b_state),         32'(IDLE));

        // TX full on ch1 with uart_tx busy
        for (int k = 1; k <= 5; k++) begin
            b_tx_dat[6 +: 6] = 6'(k);
            b_tx_push = 4'b0010;
            tick();
            check($sformatf("txfull_push%0d", k), 32'(b_tx_full[1]), (k >= 4) ? 32'd1 : 32'd0);
        end
        b_tx_push = '0;
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h44};
        run_tx(80);
        check("txfull_drained", 32'(b_tx_full), 32'd0);

        // Async reset with FIFOs partly filled and an overflow pending
        b_int_en = 4'hF;
        b_tx_dat = {6'h3F, 6'h3F, 6'h3F, 6'h3F};
        for (int k = 0; k < 4; k++) begin
            b_tx_push = (k == 0) ? 4'b1010 : 4'b0010;
            tick();
        end
        b_tx_push = '0;
        for (int k = 0; k < 5; k++) begin
            if_b.i_rx_dat   = 8'h80 | 8'(k);
            if_b.i_rx_pulse = 1'b1;
            tick();
        end
        if_b.i_rx_pulse = 1'b0;
        check("pre_rst_full",  32'(b_tx_full),  32'b0010);
        check("pre_rst_valid", 32'(b_rx_valid), 32'b0100);
        check("pre_rst_ovf",   32'(b_ovf),      32'b0100);
        check("pre_rst_int",   32'(b_int),      32'd1);
        @(posedge clk);
        #3;
        rst_b = 1'b1;
        #1;
        check("arst_valid", 32'(b_rx_valid), 32'd0);
        check("arst_full",  32'(b_tx_full),  32'd0);
        check("arst_ovf",   32'(b_ovf),      32'd0);
        check("arst_int",   32'(b_int),      32'd0);
        check("arst_start", 32'(if_b.o_tx_start), 32'd0);
        check("arst_dat",   32'(if_b.o_tx_dat),   32'd0);
        check("arst_state", 32'(b_state),    32'(IDLE));
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        tick();
        // last was ch1 before reset; after reset ch0 must win over ch3
        b_tx_dat  = {6'h15, 6'h00, 6'h00, 6'h2A};
        b_tx_push = 4'b1001;
        tick();
        b_tx_push = '0;
        exp_q = '{8'h2A, 8'hD5};
        run_tx(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
